// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-byte holding register; define UART_RX_PARITY_EN for 8E1
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic       rx_meta, rxs, rxs_d, fall;
    state_t     state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shift, shift_n;
    logic       bad, bad_n;
    logic       deliver, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic       perr_set;
`endif

    // rxs_d keeps the previous synchronized sample so a line that is already low never looks like an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign fall = rxs_d & ~rxs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            bad     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            bad     <= bad_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        bad_n     = bad;
        deliver   = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                bad_n = 1'b0;
                if (fall) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    shift_n   = {rxs, shift[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = STOP;
                    if (rxs != ^shift) begin
                        perr_set = 1'b1;
                        bad_n    = 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    state_n = IDLE;
                    if (!rxs)     ferr_set = 1'b1;
                    else if (!bad) deliver = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // An ack landing on the delivery edge frees the holding register for the new byte
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            if (deliver) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                    overrun  <= 1'b0;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (rx_ack && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) parity_err <= 1'b0;
        else          parity_err <= perr_set;
    end
`else
    assign parity_err = 1'b0;
`endif

    assign rx_busy = (state != IDLE);

endmodule
